sc_lane_shifter: RTL and testbench

Vehicle-lane stage of the Frogger datapath. Consumes the active-low tick from the lane clock divider, which sits directly upstream. Holds one lane of vehicle occupancy as a bit vector and rotates it one position per tick in a programmable direction. Tracks collisions against the frog's position mask and reports a step pulse and step count for the display and scoring logic.

---
 rtl/sc_lane_shifter.sv | 103 ++++++++++
 tb/tb_sc_lane_shifter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_lane_shifter.sv
// Frogger vehicle lane: rotates an occupancy vector once per divider tick and flags frog collisions.
// Optional macro SC_LANESHIFT_HALT_ON_HIT_EN freezes the lane after a collision until the next load.
module sc_lane_shifter #(
  parameter int unsigned           LANE_WIDTH = 8,
  parameter logic [LANE_WIDTH-1:0] LANE_INIT  = 8'b0000_0011
) (
  input  logic                  SC_LANESHIFT_CLOCK_50,
  input  logic                  SC_LANESHIFT_RESET_InLow,
  input  logic                  SC_LANESHIFT_TICK_InLow,
  input  logic                  SC_LANESHIFT_DIR_In,
  input  logic                  SC_LANESHIFT_PAUSE_In,
  input  logic                  SC_LANESHIFT_LOAD_In,
  input  logic [LANE_WIDTH-1:0] SC_LANESHIFT_PATTERN_In,
  input  logic [LANE_WIDTH-1:0] SC_LANESHIFT_FROG_In,
  output logic [LANE_WIDTH-1:0] SC_LANESHIFT_LANE_Out,
  output logic                  SC_LANESHIFT_STEP_Out,
  output logic                  SC_LANESHIFT_HIT_Out,
  output logic [7:0]            SC_LANESHIFT_STEPCOUNT_Out
);

`ifdef SC_LANESHIFT_HALT_ON_HIT_EN
  typedef enum logic [1:0] {StRun, StPaused, StHalt} state_e;
`else
  typedef enum logic [1:0] {StRun, StPaused} state_e;
`endif

  state_e                state_q;
  logic [LANE_WIDTH-1:0] lane_q;
  logic [LANE_WIDTH-1:0] lane_rot;
  logic                  step_q;
  logic                  hit_q;
  logic [7:0]            count_q;
  logic                  tick_prev_q;
  logic                  tick_armed_q;
  logic                  tick_event;
  logic                  overlap;
  logic                  shift_en;

  // A tick must be seen high once after reset before any falling level counts as an event.
  assign tick_event = ~SC_LANESHIFT_TICK_InLow & ~tick_prev_q & tick_armed_q;
  assign overlap    = |(lane_q & SC_LANESHIFT_FROG_In);
  assign shift_en   = tick_event & ~SC_LANESHIFT_LOAD_In & ~SC_LANESHIFT_PAUSE_In &
                      (state_q == StRun);

  always_comb begin
    lane_rot = lane_q;
    if (SC_LANESHIFT_DIR_In) begin
      lane_rot = {lane_q[0], lane_q[LANE_WIDTH-1:1]};
    end else begin
      lane_rot = {lane_q[LANE_WIDTH-2:0], lane_q[LANE_WIDTH-1]};
    end
  end

  always_ff @(posedge SC_LANESHIFT_CLOCK_50 or negedge SC_LANESHIFT_RESET_InLow) begin
    if (!SC_LANESHIFT_RESET_InLow) begin
      state_q      <= StRun;
      lane_q       <= LANE_INIT;
      step_q       <= 1'b0;
      hit_q        <= 1'b0;
      count_q      <= 8'd0;
      tick_prev_q  <= 1'b0;
      tick_armed_q <= 1'b0;
    end else begin
      tick_prev_q <= ~SC_LANESHIFT_TICK_InLow;
      if (SC_LANESHIFT_TICK_InLow) begin
        tick_armed_q <= 1'b1;
      end
      step_q <= 1'b0;
      if (SC_LANESHIFT_LOAD_In) begin
        lane_q  <= SC_LANESHIFT_PATTERN_In;
        count_q <= 8'd0;
        hit_q   <= 1'b0;
        state_q <= SC_LANESHIFT_PAUSE_In ? StPaused : StRun;
      end else begin
        if (overlap) begin
          hit_q <= 1'b1;
        end
        if (shift_en) begin
          lane_q  <= lane_rot;
          count_q <= count_q + 8'd1;
          step_q  <= 1'b1;
        end
`ifdef SC_LANESHIFT_HALT_ON_HIT_EN
        if (state_q == StHalt) begin
          state_q <= StHalt;
        end else if (overlap) begin
          state_q <= StHalt;
        end else begin
          state_q <= SC_LANESHIFT_PAUSE_In ? StPaused : StRun;
        end
`else
        state_q <= SC_LANESHIFT_PAUSE_In ? StPaused : StRun;
`endif
      end
    end
  end

  assign SC_LANESHIFT_LANE_Out      = lane_q;
  assign SC_LANESHIFT_STEP_Out      = step_q;
  assign SC_LANESHIFT_HIT_Out       = hit_q;
  assign SC_LANESHIFT_STEPCOUNT_Out = count_q;

endmodule

// File: tb/tb_sc_lane_shifter.sv
// Scoreboard bench for sc_lane_shifter: each expected shift is queued when the tick is driven
// and checked against lane/count when STEP_Out pulses.
module tb_sc_lane_shifter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_n;
  logic       dir;
  logic       pause;
  logic       load;
  logic [7:0] pattern;
  logic [7:0] frog;
  logic [7:0] lane;
  logic       step;
  logic       hit;
  logic [7:0] cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int steps_seen = 0;
  logic [7:0]  m_lane;
  logic [7:0]  m_cnt;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  sc_lane_shifter #(
    .LANE_WIDTH (8),
    .LANE_INIT  (8'h03)
  ) u_dut (
    .SC_LANESHIFT_CLOCK_50      (clk),
    .SC_LANESHIFT_RESET_InLow   (rst_n),
    .SC_LANESHIFT_TICK_InLow    (tick_n),
    .SC_LANESHIFT_DIR_In        (dir),
    .SC_LANESHIFT_PAUSE_In      (pause),
    .SC_LANESHIFT_LOAD_In       (load),
    .SC_LANESHIFT_PATTERN_In    (pattern),
    .SC_LANESHIFT_FROG_In       (frog),
    .SC_LANESHIFT_LANE_Out      (lane),
    .SC_LANESHIFT_STEP_Out      (step),
    .SC_LANESHIFT_HIT_Out       (hit),
    .SC_LANESHIFT_STEPCOUNT_Out (cnt)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pops one expectation per STEP pulse; a pulse with nothing queued is itself a failure.
  always @(negedge clk) begin
    if (rst_n && step) begin
      steps_seen++;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_step", 16'd1, 16'd0);
      end else begin
        logic [15:0] e;
        e = sb_q.pop_front();
        check("sb_lane", {8'd0, lane}, {8'd0, e[15:8]});
        check("sb_cnt", {8'd0, cnt}, {8'd0, e[7:0]});
      end
    end
  end

  function automatic logic [7:0] rot(input logic [7:0] v, input logic d);
    return d ? {v[0], v[7:1]} : {v[6:0], v[7]};
  endfunction

  task automatic push_shift();
    m_lane = rot(m_lane, dir);
    m_cnt  = m_cnt + 8'd1;
    sb_q.push_back({m_lane, m_cnt});
  endtask

  // Tick low for one edge, then high for `gap` edges.
  task automatic do_tick(input bit expect_shift, input int gap);
    @(posedge clk); #1 tick_n = 1'b0;
    if (expect_shift) push_shift();
    @(posedge clk); #1 tick_n = 1'b1;
    repeat (gap - 1) @(posedge clk);
  endtask

  task automatic do_load(input logic [7:0] p);
    @(posedge clk); #1 load = 1'b1; pattern = p;
    @(posedge clk); #1 load = 1'b0;
    m_lane = p;
    m_cnt  = 8'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; tick_n = 1'b1; dir = 1'b0; pause = 1'b0; load = 1'b0;
    pattern = 8'h00; frog = 8'h00;
    m_lane = 8'h03; m_cnt = 8'd0;
    #23;
    check("rst_lane", {8'd0, lane}, 16'h03);
    check("rst_step", {15'd0, step}, 16'd0);
    check("rst_hit", {15'd0, hit}, 16'd0);
    check("rst_cnt", {8'd0, cnt}, 16'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Eight left rotations return to the start, then one right.
    for (int i = 0; i < 8; i++) do_tick(1'b1, 3);
    #1;
    check("left8_lane", {8'd0, lane}, 16'h03);
    check("left8_cnt", {8'd0, cnt}, 16'd8);
    check("left8_steps", steps_seen[15:0], 16'd8);
    dir = 1'b1;
    do_tick(1'b1, 3);
    check("right_lane", {8'd0, lane}, 16'h81);

    // Held-low tick: exactly one shift.
    dir = 1'b0;
    @(posedge clk); #1 tick_n = 1'b0;
    push_shift();
    repeat (5) @(posedge clk);
    #1 tick_n = 1'b1;
    repeat (2) @(posedge clk);
    check("hold_cnt", {8'd0, cnt}, 16'd10);
    check("hold_lane", {8'd0, lane}, 16'h03);

    // Reach 0x30, then reset mid-cycle with the tick low and keep it low through release.
    do_load(8'h18);
    do_tick(1'b1, 3);
    check("pre_rst_lane", {8'd0, lane}, 16'h30);
    @(posedge clk); #1 tick_n = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_lane", {8'd0, lane}, 16'h03);
    check("async_cnt", {8'd0, cnt}, 16'd0);
    check("async_step", {15'd0, step}, 16'd0);
    check("async_hit", {15'd0, hit}, 16'd0);
    m_lane = 8'h03; m_cnt = 8'd0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("held_rel_lane", {8'd0, lane}, 16'h03);
    check("held_rel_cnt", {8'd0, cnt}, 16'd0);
    tick_n = 1'b1;
    @(posedge clk);
    do_tick(1'b1, 3);
    check("rearm_lane", {8'd0, lane}, 16'h06);

    // Set HIT, then LOAD coinciding with a tick event.
    frog = 8'h02;
    repeat (2) @(posedge clk);
    #1 check("hit_set", {15'd0, hit}, 16'd1);
    frog = 8'h00;
    @(posedge clk); #1 load = 1'b1; pattern = 8'hF0; tick_n = 1'b0;
    @(posedge clk); #1 load = 1'b0; tick_n = 1'b1;
    m_lane = 8'hF0; m_cnt = 8'd0;
    check("load_lane", {8'd0, lane}, 16'hF0);
    check("load_step", {15'd0, step}, 16'd0);
    check("load_cnt", {8'd0, cnt}, 16'd0);
    check("load_hit", {15'd0, hit}, 16'd0);

    // Paused ticks are dropped.
    pause = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) do_tick(1'b0, 3);
    #1;
    check("pause_lane", {8'd0, lane}, 16'hF0);
    check("pause_cnt", {8'd0, cnt}, 16'd0);
    pause = 1'b0;
    repeat (2) @(posedge clk);

    // Collision: lane 0x03 shifts into frog at bit 2.
    do_load(8'h03);
    frog = 8'h04;
    @(posedge clk); #1 tick_n = 1'b0;
    push_shift();
    @(posedge clk); #1 tick_n = 1'b1;
    check("coll_lane", {8'd0, lane}, 16'h06);
    check("coll_hit_early", {15'd0, hit}, 16'd0);
    @(posedge clk); #1;
    check("coll_hit", {15'd0, hit}, 16'd1);
    @(posedge clk);
`ifdef SC_LANESHIFT_HALT_ON_HIT_EN
    do_tick(1'b0, 3);
    #1 check("halt_lane", {8'd0, lane}, 16'h06);
`else
    do_tick(1'b1, 3);
    #1 check("nohalt_lane", {8'd0, lane}, 16'h0C);
`endif
    check("coll_hit_sticky", {15'd0, hit}, 16'd1);

    // 256 back-to-back ticks at the minimum period wrap the count and restore the lane.
    frog = 8'h00;
    do_load(8'hA5);
    for (int i = 0; i < 256; i++) do_tick(1'b1, 1);
    repeat (2) @(posedge clk);
    #1;
    check("wrap_cnt", {8'd0, cnt}, 16'd0);
    check("wrap_lane", {8'd0, lane}, 16'hA5);
    check("wrap_hit", {15'd0, hit}, 16'd0);
    check("sb_drain", sb_q.size(), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
